ex_muldiv_seq: RTL

Multi-cycle sequencer for RV32M multiply/divide operations in the EX stage. It accepts one M-extension operation from the EX stage, holds the pipeline with a stall while an iterative shift-add multiplier or restoring divider runs, and returns a one-cycle result pulse that the EX stage muxes into `opr_res`. It sits beside the ALU, and the EX stage selects between them on `funct7 == 7'b0000001`.

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/ex_muldiv_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
`ifndef MULDIV_PKG_SV
`define MULDIV_PKG_SV
package muldiv_pkg;

   localparam int unsigned MD_ITER       = 32;
   localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } mdop_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } mdstate_t;

   function automatic logic is_div_f(input mdop_t op);
      return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

   function automatic logic op_signed_a_f(input mdop_t op);
      return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction

   function automatic logic op_signed_b_f(input mdop_t op);
      return op inside {MD_MULH, MD_DIV, MD_REM};
   endfunction

endpackage
`endif

// File: rtl/ex_muldiv_seq.sv
// EX-stage RV32M sequencer: iterative shift-add multiply / restoring divide
// sharing one 64-bit accumulator, with stall and one-cycle result pulse.
module ex_muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] opr_a_i,
   input  logic [XLEN-1:0] opr_b_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            out_valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   mdstate_t          state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   mdop_t             op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   dvs_q, dvs_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   res_q, res_d;

   mdop_t             op_in;
   logic              a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     msum, rsh, rdiff;
   logic [2*XLEN-1:0] mul_next, div_next, prod;

   always_comb begin
      op_in    = mdop_t'(funct3_i);
      a_neg    = op_signed_a_f(op_in) && opr_a_i[XLEN-1];
      b_neg    = op_signed_b_f(op_in) && opr_b_i[XLEN-1];
      a_mag    = a_neg ? ('0 - opr_a_i) : opr_a_i;
      b_mag    = b_neg ? ('0 - opr_b_i) : opr_b_i;
      div_zero = is_div_f(op_in) && (opr_b_i == '0);
      div_ovf  = (op_in inside {MD_DIV, MD_REM}) &&
                 (opr_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (opr_b_i == '1);
   end

   // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
   always_comb begin
      msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, dvs_q};
      mul_next = acc_q[0] ? {msum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
      rsh      = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      rdiff    = rsh - {1'b0, dvs_q};
      div_next = (rsh >= {1'b0, dvs_q}) ? {rdiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                        : {rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      prod     = neg_q ? ('0 - acc_q) : acc_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rd_d    = rd_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      neg_d   = neg_q;
      res_d   = res_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i && !flush_i) begin
               op_d  = op_in;
               rd_d  = rd_i;
               cnt_d = '0;
               if (div_zero) begin
                  res_d   = (op_in inside {MD_DIV, MD_DIVU}) ? '1 : opr_a_i;
                  state_d = ST_DONE;
               end else if (div_ovf) begin
                  res_d   = (op_in == MD_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
                  state_d = ST_DONE;
               end else begin
                  dvs_d   = is_div_f(op_in) ? b_mag : a_mag;
                  acc_d   = {{XLEN{1'b0}}, (is_div_f(op_in) ? a_mag : b_mag)};
                  neg_d   = (op_in inside {MD_REM, MD_REMU}) ? a_neg : (a_neg ^ b_neg);
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (flush_i) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = is_div_f(op_q) ? div_next : mul_next;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'(MD_ITER - 1)) state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (flush_i) begin
               state_d = ST_IDLE;
            end else begin
               unique case (op_q)
                  MD_MUL:                       res_d = prod[XLEN-1:0];
                  MD_MULH, MD_MULHSU, MD_MULHU: res_d = prod[2*XLEN-1:XLEN];
                  MD_DIV, MD_DIVU:              res_d = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
                  default:                      res_d = neg_q ? ('0 - acc_q[2*XLEN-1:XLEN])
                                                               : acc_q[2*XLEN-1:XLEN];
               endcase
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_MUL;
         rd_q    <= '0;
         acc_q   <= '0;
         dvs_q   <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
      end
   end

   assign stall_o     = rst_n && (((state_q == ST_IDLE) && start_i && !flush_i) ||
                                  (state_q == ST_CALC) || (state_q == ST_FIX));
   assign out_valid_o = rst_n && (state_q == ST_DONE) && !flush_i;
   assign result_o    = res_q;
   assign rd_o        = rd_q;

endmodule
